// File: rtl/mram_cmd_serializer_pkg.sv
// Purpose : shared constants, control-bit indices and FSM state type for the MRAM command serializer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package mram_ser_pkg;

  // Default lane widths: address, write data and control.
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CTRL_W = 5;

  // Bit positions inside the control word.
  localparam int CTRL_CE = 0;  // chip_en
  localparam int CTRL_WE = 1;  // write_en
  localparam int CTRL_OE = 2;  // out_en
  localparam int CTRL_LB = 3;  // lower_byte_en
  localparam int CTRL_UB = 4;  // upper_byte_en

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // The frame is as long as the widest lane.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mram_cmd_serializer_if.sv
// Purpose : parallel command handshake bundle (valid/ready + address, data, control).
// Latency : n/a (wiring only).
// Backpressure: producer holds cmd_* stable with cmd_valid high until it sees cmd_ready.
// Ports   : cmd_valid, cmd_addr, cmd_data, cmd_ctrl (producer -> serializer); cmd_ready (serializer -> producer).
interface mram_cmd_if #(
  parameter int ADDR_W = mram_ser_pkg::DEF_ADDR_W,
  parameter int DATA_W = mram_ser_pkg::DEF_DATA_W,
  parameter int CTRL_W = mram_ser_pkg::DEF_CTRL_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [CTRL_W-1:0] cmd_ctrl;

  modport master (output cmd_valid, cmd_addr, cmd_data, cmd_ctrl, input cmd_ready);
  modport slave  (input cmd_valid, cmd_addr, cmd_data, cmd_ctrl, output cmd_ready);
endinterface

// File: rtl/mram_cmd_serializer_piso_shift.sv
// Purpose : parallel-in serial-out lane register, LSB first, zero fill from the top.
// Latency : bit 0 visible the cycle after load; one new bit per shift.
// Backpressure: none; driven purely by load/shift from the controlling FSM.
// Ports   : clk, rst (async active-low), load + din (capture), shift (advance), ser (registered serial bit).
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             ser
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Shifting in zeros means the lane idles at 0 once its bits are used up,
  // which gives the padding slots and the post-frame zero for free.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = sr_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser = sr_q[0];

endmodule

// File: rtl/mram_cmd_serializer.sv
// Purpose : takes one parallel MRAM command per handshake and emits it as a framed LSB-first serial burst.
// Latency : bit 0 and ctrl_en appear at the accepting edge; frame lasts FRAME_LEN cycles, then GAP_CYCLES idle.
// Backpressure: cmd_ready is high only in IDLE; commands offered during a frame or gap wait.
// Ports   : clk, rst (async active-low), cmd (slave handshake), ctrl_en/addr_ser/data_ser/ctrl_ser (serial lanes),
//           busy (frame or gap in progress), frame_done (one-cycle pulse at frame end). All outputs registered.
module mram_cmd_serializer #(
  parameter int ADDR_W     = mram_ser_pkg::DEF_ADDR_W,
  parameter int DATA_W     = mram_ser_pkg::DEF_DATA_W,
  parameter int CTRL_W     = mram_ser_pkg::DEF_CTRL_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mram_cmd_if.slave  cmd,
  output logic       ctrl_en,
  output logic       addr_ser,
  output logic       data_ser,
  output logic       ctrl_ser,
  output logic       busy,
  output logic       frame_done
);
  import mram_ser_pkg::*;

  localparam int FRAME_LEN = max3(ADDR_W, DATA_W, CTRL_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               ctrl_en_q, ctrl_en_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               load, shift;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    ctrl_en_d    = ctrl_en_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && cmd_ready_q) begin
          load      = 1'b1;
          ctrl_en_d = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Shift on every frame cycle, including the last: the final shift
        // empties every lane so they all drop to 0 together with ctrl_en.
        shift = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          ctrl_en_d    = 1'b0;
          frame_done_d = 1'b1;
          gap_cnt_d    = '0;
          state_d      = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered, so derive them from the next state.
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ctrl_en_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ctrl_en_q    <= ctrl_en_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  piso_shift #(.WIDTH(ADDR_W)) u_addr_lane (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .din(cmd.cmd_addr), .ser(addr_ser)
  );
  piso_shift #(.WIDTH(DATA_W)) u_data_lane (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .din(cmd.cmd_data), .ser(data_ser)
  );
  piso_shift #(.WIDTH(CTRL_W)) u_ctrl_lane (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .din(cmd.cmd_ctrl), .ser(ctrl_ser)
  );

  assign cmd.cmd_ready = cmd_ready_q;
  assign ctrl_en       = ctrl_en_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_mram_cmd_serializer.sv
// Purpose : self-checking bench for mram_cmd_serializer (table vectors, corner sequences, random commands).
// Latency : checks frame position, frame length, gap length and ready return against the frame rules.
// Backpressure: exercises held valid, valid changing while busy, and reset mid-frame.
module tb_mram_cmd_serializer;

  localparam int FL  = 20;  // frame length at default widths
  localparam int GAP = 2;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    logic [4:0]  ctrl;
    logic [19:0] exp_addr;  // expected 20-slot content of each lane, slot i = bit i
    logic [19:0] exp_data;
    logic [19:0] exp_ctrl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mram_cmd_if #(.ADDR_W(20), .DATA_W(16), .CTRL_W(5)) cmd ();

  logic ctrl_en, addr_ser, data_ser, ctrl_ser, busy, frame_done;

  mram_cmd_serializer #(.ADDR_W(20), .DATA_W(16), .CTRL_W(5), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .cmd(cmd),
    .ctrl_en(ctrl_en), .addr_ser(addr_ser), .data_ser(data_ser), .ctrl_ser(ctrl_ser),
    .busy(busy), .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: each lane carries its value LSB first, zero-extended to the frame.
  function automatic vec_t model(input logic [19:0] a, input logic [15:0] d, input logic [4:0] c);
    vec_t v;
    v.addr = a; v.data = d; v.ctrl = c;
    v.exp_addr = a;
    v.exp_data = {4'b0, d};
    v.exp_ctrl = {15'b0, c};
    return v;
  endfunction

  // Called at a negedge. Offers v, waits for acceptance, then checks the whole
  // frame, the end-of-frame cycle and the gap. Returns at the negedge where
  // cmd_ready should be back (cycle k+FL+GAP).
  task automatic send_frame(input vec_t v, input bit hold, input bit alt_mid, input vec_t alt,
                            input string tag, output int hs);
    int waited, en_cnt, fd_cnt, bad, gap_bad;
    logic [19:0] ra, rd, rc;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_addr  = v.addr;
    cmd.cmd_data  = v.data;
    cmd.cmd_ctrl  = v.ctrl;
    waited = 0;
    while (!cmd.cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd.cmd_ready) begin
      checks++; errors++;
      $display("FAIL %s handshake_timeout: cmd_ready=0 required 1", tag);
      cmd.cmd_valid = 1'b0;
      hs = -1000;
      return;
    end
    @(posedge clk);
    @(negedge clk);  // cycle k
    hs = cyc;
    if (!hold) begin
      cmd.cmd_valid = 1'b0;
      cmd.cmd_addr  = ~v.addr;
      cmd.cmd_data  = ~v.data;
      cmd.cmd_ctrl  = ~v.ctrl;
    end
    en_cnt = 0; fd_cnt = 0; bad = 0; gap_bad = 0;
    ra = '0; rd = '0; rc = '0;
    for (int i = 0; i < FL; i++) begin
      en_cnt += int'(ctrl_en);
      fd_cnt += int'(frame_done);
      if (cmd.cmd_ready || !busy) bad++;
      ra[i] = addr_ser;
      rd[i] = data_ser;
      rc[i] = ctrl_ser;
      if (alt_mid && i == 5) begin
        cmd.cmd_addr = alt.addr;
        cmd.cmd_data = alt.data;
        cmd.cmd_ctrl = alt.ctrl;
      end
      @(negedge clk);
    end
    // cycle k+FL
    chk({tag, " ctrl_en_cycles"}, 32'(en_cnt), 32'(FL));
    chk({tag, " ctrl_en_end"}, 32'(ctrl_en), 32'd0);
    chk({tag, " addr_lane"}, 32'(ra), 32'(v.exp_addr));
    chk({tag, " data_lane"}, 32'(rd), 32'(v.exp_data));
    chk({tag, " ctrl_lane"}, 32'(rc), 32'(v.exp_ctrl));
    chk({tag, " frame_done_pulse"}, 32'(fd_cnt * 2 + int'(frame_done)), 32'd1);
    chk({tag, " lanes_zero_end"}, 32'({addr_ser, data_ser, ctrl_ser}), 32'd0);
    chk({tag, " ready_busy_in_frame"}, 32'(bad), 32'd0);
    chk({tag, " busy_ready_end"}, 32'({busy, cmd.cmd_ready}), 32'b10);
    for (int g = 1; g <= GAP; g++) begin
      @(negedge clk);
      if (ctrl_en || frame_done) gap_bad++;
      if (g < GAP && (cmd.cmd_ready || !busy)) gap_bad++;
    end
    chk({tag, " gap_quiet"}, 32'(gap_bad), 32'd0);
    chk({tag, " ready_return"}, 32'({cmd.cmd_ready, busy, ctrl_en}), 32'b100);
  endtask

  initial begin
    int hs1, hs2, prev_hs, pend;
    bit prev_hold, hold;
    vec_t none, rv;

    tbl[0] = '{20'hABCDE, 16'h1234, 5'b10011, 20'hABCDE, 20'h01234, 20'h00013};
    tbl[1] = '{20'h00001, 16'hFFFF, 5'b11111, 20'h00001, 20'h0FFFF, 20'h0001F};
    tbl[2] = '{20'hFFFFF, 16'h0000, 5'b00000, 20'hFFFFF, 20'h00000, 20'h00000};
    tbl[3] = '{20'h5A5A5, 16'hA5A5, 5'b01010, 20'h5A5A5, 20'h0A5A5, 20'h0000A};
    none = tbl[0];

    cmd.cmd_valid = 1'b0;
    cmd.cmd_addr  = '0;
    cmd.cmd_data  = '0;
    cmd.cmd_ctrl  = '0;

    // Reset: everything low for three cycles, ready one edge after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outputs_%0d", i),
          32'({cmd.cmd_ready, ctrl_en, addr_ser, data_ser, ctrl_ser, busy, frame_done}), 32'd0);
    end
    rst = 1'b1;
    #1 chk("ready_before_first_edge", 32'(cmd.cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'({cmd.cmd_ready, ctrl_en, busy}), 32'b100);

    // Table vectors, one isolated frame each.
    for (int t = 0; t < 4; t++) begin
      send_frame(tbl[t], 1'b0, 1'b0, none, $sformatf("vec%0d", t), hs1);
      repeat (2) @(negedge clk);
    end

    // Back-to-back with valid held: second frame starts FL+GAP+1 edges later.
    send_frame(tbl[1], 1'b1, 1'b0, none, "b2b_first", hs1);
    send_frame(tbl[2], 1'b0, 1'b0, none, "b2b_second", hs2);
    chk("b2b_spacing", 32'(hs2 - hs1), 32'(FL + GAP + 1));

    // Inputs change at cycle 5 of a frame: frame keeps captured values,
    // the new command waits for the earliest legal edge.
    @(negedge clk);
    send_frame(tbl[0], 1'b1, 1'b1, tbl[3], "busy_change", hs1);
    send_frame(tbl[3], 1'b0, 1'b0, none, "after_busy_change", hs2);
    chk("busy_change_spacing", 32'(hs2 - hs1), 32'(FL + GAP + 1));

    // Reset at bit 10 of a frame.
    @(negedge clk);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_addr  = tbl[0].addr;
    cmd.cmd_data  = tbl[0].data;
    cmd.cmd_ctrl  = tbl[0].ctrl;
    @(posedge clk);
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_frame_active", 32'({ctrl_en, busy}), 32'b11);
    #2 rst = 1'b0;
    #1 chk("midrst_async_clear",
           32'({cmd.cmd_ready, ctrl_en, addr_ser, data_ser, ctrl_ser, busy, frame_done}), 32'd0);
    pend = 0;
    repeat (3) begin
      @(negedge clk);
      if ({cmd.cmd_ready, ctrl_en, addr_ser, data_ser, ctrl_ser, busy, frame_done} != 7'd0) pend++;
    end
    chk("midrst_held_quiet", 32'(pend), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after_release", 32'(cmd.cmd_ready), 32'd1);
    send_frame(tbl[0], 1'b0, 1'b0, none, "after_midrst", hs1);

    // Random commands against the model, randomly held back-to-back.
    prev_hold = 1'b0;
    prev_hs   = 0;
    for (int n = 0; n < 10; n++) begin
      rv   = model(20'($urandom), 16'($urandom), 5'($urandom));
      hold = 1'($urandom_range(0, 1));
      send_frame(rv, hold, 1'b0, none, $sformatf("rand%0d", n), hs1);
      if (prev_hold) chk($sformatf("rand%0d_spacing", n), 32'(hs1 - prev_hs), 32'(FL + GAP + 1));
      prev_hold = hold;
      prev_hs   = hs1;
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    cmd.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle", 32'({cmd.cmd_ready, busy, ctrl_en}), 32'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mram_cmd_serializer.md
Name: mram_cmd_serializer

Overview:
Upstream feeder for serial_to_parallel. It accepts one parallel MRAM command per valid/ready handshake: a 20-bit address, 16-bit write data and 5 control bits. It then drives the command out as one framed serial burst, LSB first, on the addr_in/data_in/ctrl/ctrl_en lines that serial_to_parallel consumes. It sits between the host-side command source and the deserializer at the MRAM pins.

Parameters:
ADDR_W, 20, address width and address-lane bit count
DATA_W, 16, data width and data-lane bit count
CTRL_W, 5, control-lane bit count
GAP_CYCLES, 2, extra idle cycles with ctrl_en low after each frame (0 allowed)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_addr  in  ADDR_W  command address
cmd_data  in  DATA_W  command write data
cmd_ctrl  in  CTRL_W  control bits: [0] chip_en, [1] write_en, [2] out_en, [3] lower_byte_en, [4] upper_byte_en (raw values, passed through unchanged)
ctrl_en  out  1  frame strobe to deserializer
addr_ser  out  1  serial address lane
data_ser  out  1  serial data lane
ctrl_ser  out  1  serial control lane
busy  out  1  frame or gap in progress
frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Localparam FRAME_LEN = max(ADDR_W, DATA_W, CTRL_W); this is 20 at the defaults.
- All outputs are registered. While rst=0 every output is 0, including cmd_ready.
- cmd_ready rises on the first rising edge after reset release.
- State machine:
  - IDLE -> SHIFT on cmd_valid && cmd_ready.
  - SHIFT -> GAP after FRAME_LEN bit-cycles.
  - GAP -> IDLE after GAP_CYCLES cycles. If GAP_CYCLES=0, SHIFT -> IDLE directly.
- cmd_ready = 1 only in IDLE. busy = 1 in SHIFT and GAP.
- Handshake at edge k:
  - cmd_addr, cmd_data and cmd_ctrl are captured into shift registers. Inputs are not sampled again until the next handshake.
  - At the same edge, ctrl_en goes 1 and bit 0 of each lane is driven.
  - Bit i appears on the lanes in cycle k+i, for i = 0..FRAME_LEN-1.
- Lane padding: a lane shorter than FRAME_LEN drives 0 for its remaining bit slots. data_ser is 0 in slots 16..19; ctrl_ser is 0 in slots 5..19.
- Frame end, edge k+FRAME_LEN:
  - ctrl_en, addr_ser, data_ser and ctrl_ser go 0.
  - frame_done is 1 for exactly one cycle.
- ctrl_en is high for exactly FRAME_LEN consecutive cycles per frame, never more and never less.
- ctrl_en stays low for at least GAP_CYCLES+1 cycles between frames. Earliest next handshake is edge k+FRAME_LEN+GAP_CYCLES+1.
- cmd_valid while busy: ignored. The producer holds the command until cmd_ready.
- cmd_valid dropping with ready=0: no effect.
- Back-to-back valid: the next frame starts at the earliest legal edge.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0 and shift registers cleared. No frame_done pulse. The partial frame is abandoned; the downstream stage sees ctrl_en fall early and the command is lost.
- Lane changes occur only on rising edges. The deserializer samples mid-cycle or on the following edge.

Decomposition:
- Package mram_ser_pkg holds:
  - ADDR_W, DATA_W and CTRL_W default constants.
  - Control bit indices: CTRL_CE=0, CTRL_WE=1, CTRL_OE=2, CTRL_LB=3, CTRL_UB=4.
  - FSM state enum {IDLE, SHIFT, GAP}.
- One sub-module, piso_shift: parameterised width, load, shift, LSB-first serial out, zero fill. Instantiated three times, once per lane.
- The top holds the FSM, the bit counter (ceil(log2(FRAME_LEN+1)) bits) and the gap counter.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. -> All outputs 0 during reset; cmd_ready=1 one edge after release; ctrl_en=0.
- Single write: addr=20'hABCDE, data=16'h1234, ctrl=5'b10011. -> ctrl_en high for exactly 20 cycles.
  - addr_ser sequence 0,1,1,1,1,0,1,1,...; reassembled value = 0xABCDE.
  - data_ser reassembled = 0x1234, then four 0s.
  - ctrl_ser = 1,1,0,0,1 then 15 zeros.
  - frame_done pulses once at cycle 20; cmd_ready returns at cycle 22.
- Back-to-back: cmd_valid held high with two commands (0x00001/0xFFFF, 0xFFFFF/0x0000). -> Second frame's ctrl_en rises exactly 23 edges after the first; ctrl_en low for 3 cycles in between.
- Valid while busy: change cmd_addr/cmd_data at cycle 5 of a frame. -> Serial output still carries the originally captured values; no second frame starts early.
- Mid-frame reset: assert rst=0 at bit 10. -> All lanes and ctrl_en go 0 asynchronously; no frame_done. After release, a new command transmits correctly.
- Loopback with serial_to_parallel (its active-high reset tied to ~rst): after ctrl_en falls, addr_out=20'hABCDE, data_out=16'h1234, and chip_en/write_en/out_en/lower_byte_en/upper_byte_en match 1,1,0,0,1.
